// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshakes on both sides. Single-cycle logic and
// arithmetic ops; SHL iterates one bit per cycle and MUL runs a WIDTH-cycle shift-add.
module alu_seq #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       s,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] r,
   output logic [3:0]       flags
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0]  CNT_FULL = CW'(WIDTH);
   localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
   localparam logic [WIDTH:0] WLIM     = (WIDTH + 1)'(WIDTH);

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_NOT = 3'b101;
   localparam logic [2:0] OP_SHL = 3'b110;
   localparam logic [2:0] OP_MUL = 3'b111;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t                 state, state_nxt;
   logic [2:0]             op;
   logic [CW-1:0]          cnt;
   logic [WIDTH-1:0]       mcand;
   logic [2*WIDTH-1:0]     prod;
   logic [WIDTH-1:0]       sh;

   logic [WIDTH:0]         sum, dif;
   logic [WIDTH-1:0]       alu_r;
   logic                   alu_c, alu_v;
   logic [CW-1:0]          shl_k;
   logic [WIDTH:0]         prod_sum;
   logic [2*WIDTH-1:0]     prod_nxt;
   logic [WIDTH-1:0]       sh_nxt;

   function automatic logic [3:0] flag_pack(input logic [WIDTH-1:0] res,
                                            input logic c, input logic v);
      return {res[WIDTH-1], v, c, (res == '0)};
   endfunction

   assign in_ready  = (state == IDLE) && !rst;
   assign out_valid = (state == DONE);

   // Shift count saturates at WIDTH: any larger amount clears the operand anyway.
   always_comb begin
      if ({1'b0, b} >= WLIM) shl_k = CNT_FULL;
      else                   shl_k = b[CW-1:0];
   end

   always_comb begin
      sum   = {1'b0, a} + {1'b0, b};
      dif   = {1'b0, a} - {1'b0, b};
      alu_r = '0;
      alu_c = 1'b0;
      alu_v = 1'b0;
      case (s)
         OP_ADD: begin
            alu_r = sum[WIDTH-1:0];
            alu_c = sum[WIDTH];
            alu_v = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            alu_r = dif[WIDTH-1:0];
            alu_c = dif[WIDTH];
            alu_v = (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);
         end
         OP_AND:  alu_r = a & b;
         OP_OR:   alu_r = a | b;
         OP_XOR:  alu_r = a ^ b;
         OP_NOT:  alu_r = ~a;
         OP_SHL:  alu_r = a;
         default: alu_r = '0;
      endcase
   end

   // One iteration of each multi-cycle op; upper product half keeps its carry.
   always_comb begin
      prod_sum = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
      prod_nxt = {prod_sum, prod[WIDTH-1:1]};
      sh_nxt   = {sh[WIDTH-2:0], 1'b0};
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (in_valid) begin
            if (s == OP_MUL || (s == OP_SHL && shl_k != '0)) state_nxt = BUSY;
            else                                              state_nxt = DONE;
         end
         BUSY:    if (cnt == CNT_ONE) state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op    <= '0;
         cnt   <= '0;
         mcand <= '0;
         prod  <= '0;
         sh    <= '0;
         r     <= '0;
         flags <= '0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               op    <= s;
               mcand <= a;
               prod  <= {{WIDTH{1'b0}}, b};
               sh    <= a;
               cnt   <= (s == OP_MUL) ? CNT_FULL : shl_k;
               if (!(s == OP_MUL || (s == OP_SHL && shl_k != '0))) begin
                  r     <= alu_r;
                  flags <= flag_pack(alu_r, alu_c, alu_v);
               end
            end
            BUSY: begin
               cnt <= cnt - CNT_ONE;
               if (op == OP_MUL) prod <= prod_nxt;
               else              sh   <= sh_nxt;
               if (cnt == CNT_ONE) begin
                  if (op == OP_MUL) begin
                     r     <= prod_nxt[WIDTH-1:0];
                     flags <= flag_pack(prod_nxt[WIDTH-1:0],
                                        |prod_nxt[2*WIDTH-1:WIDTH], 1'b0);
                  end else begin
                     r     <= sh_nxt;
                     flags <= flag_pack(sh_nxt, sh[WIDTH-1], 1'b0);
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq at WIDTH=8: directed cases followed by random operations,
// each compared against an arithmetic reference model.
module tb_alu_seq;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] a, b;
   logic [2:0] s;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] r;
   logic [3:0] flags;

   int vectors = 0;
   int miscompares = 0;

   alu_seq #(.WIDTH(8)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .s(s), .out_valid(out_valid), .out_ready(out_ready),
      .r(r), .flags(flags)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: flags are {n, v, c, z}; latency counts edges from the accepting edge.
   task automatic model(input int ua, input int ub, input logic [2:0] op,
                        output logic [7:0] er, output logic [3:0] ef, output int el);
      int sa, sb, res, k, c, v;
      sa = (ua > 127) ? ua - 256 : ua;
      sb = (ub > 127) ? ub - 256 : ub;
      c = 0; v = 0; el = 1; res = 0;
      case (op)
         3'd0: begin res = ua + ub; c = (res > 255); v = (sa + sb > 127) || (sa + sb < -128); end
         3'd1: begin res = ua - ub; c = (ua < ub);   v = (sa - sb > 127) || (sa - sb < -128); end
         3'd2: res = ua & ub;
         3'd3: res = ua | ub;
         3'd4: res = ua ^ ub;
         3'd5: res = ~ua;
         3'd6: begin
            k = (ub > 8) ? 8 : ub;
            res = ua << k;
            c = (k >= 1) ? ((ua >> (8 - k)) & 1) : 0;
            el = k + 1;
         end
         default: begin res = ua * ub; c = (res > 255); el = 9; end
      endcase
      er = res[7:0];
      ef = {er[7], v[0], c[0], (er == 8'h00)};
   endtask

   task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_, input logic [2:0] ts,
                         input int hold, input string tag);
      logic [7:0] er;
      logic [3:0] ef;
      int el, lat, waitc;
      model(int'(ta), int'(tb_), ts, er, ef, el);
      waitc = 0;
      while (!in_ready && waitc < 20) begin @(posedge clk); #1; waitc++; end
      check({tag, "_ready"}, in_ready, 1'b1);
      a = ta; b = tb_; s = ts; in_valid = 1'b1;
      out_ready = (hold == 0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      a = ~ta; b = $urandom; s = $urandom;
      lat = 1;
      while (!out_valid && lat < 40) begin
         check({tag, "_busy_rdy"}, in_ready, 1'b0);
         @(posedge clk); #1;
         lat++;
      end
      check({tag, "_lat"}, lat, el);
      check({tag, "_r"}, r, er);
      check({tag, "_flags"}, flags, ef);
      check({tag, "_excl"}, in_ready, 1'b0);
      for (int i = 0; i < hold; i++) begin
         in_valid = $urandom_range(0, 1);
         a = $urandom; b = $urandom; s = $urandom;
         @(posedge clk); #1;
         check({tag, "_hold"}, {out_valid, in_ready, r, flags}, {1'b1, 1'b0, er, ef});
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      if (hold != 0) begin @(posedge clk); #1; end
      else begin @(posedge clk); #1; end
      check({tag, "_release"}, {out_valid, in_ready}, 2'b01);
      out_ready = 1'b0;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; s = '0;
      #1;
      check("reset", {out_valid, in_ready, r, flags}, 14'h0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      run_op(8'h33, 8'hCC, 3'd0, 1, "add_ff");
      run_op(8'h33, 8'hCC, 3'd1, 1, "sub");
      run_op(8'h7F, 8'h01, 3'd0, 1, "add_ovf");
      run_op(8'h10, 8'h11, 3'd7, 1, "mul");
      run_op(8'h81, 8'h01, 3'd6, 1, "shl1");
      run_op(8'hFF, 8'h09, 3'd6, 1, "shl9");
      run_op(8'hA5, 8'h00, 3'd6, 1, "shl0");
      run_op(8'h3C, 8'h5A, 3'd4, 3, "backpressure");
      run_op(8'h80, 8'h01, 3'd1, 0, "sub_ovf");
      run_op(8'h0F, 8'h00, 3'd5, 0, "not");

      // Abort a multiply in its fourth busy cycle.
      while (!in_ready) begin @(posedge clk); #1; end
      a = 8'h10; b = 8'h11; s = 3'd7; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;
      #1 check("abort", {out_valid, in_ready, r, flags}, 14'h0);
      repeat (2) begin
         @(posedge clk); #1;
         check("abort_hold", {out_valid, r, flags}, 13'h0);
      end
      rst = 1'b0;
      run_op(8'h33, 8'hCC, 3'd4, 1, "xor_after_rst");

      for (int i = 0; i < 60; i++) begin
         logic [7:0] ra, rb;
         logic [2:0] rs;
         ra = $urandom; rb = $urandom; rs = $urandom;
         if (rs == 3'd6) rb = $urandom_range(0, 10);
         run_op(ra, rb, rs, $urandom_range(0, 2), "rand");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
